// File: rtl/rr_request_manager.sv
// rr_request_manager
// Requester side of a round-robin req/grant interface. Each client keeps a
// saturating pending-job counter and runs its own small FSM
// (IDLE -> REQ -> OWN -> RELEASE). While it owns the resource, it holds it for
// HOLD_CYCLES granted cycles per job. After each job it drops req for one
// cycle so the arbiter can rotate to another client.
//
// Optional build macro: RR_PROTOCOL_CHECK_EN
//   When defined, the module adds a sticky protocol_err output. It flags:
//   - a grant to a client that is not requesting or owning,
//   - a multi-hot grant vector,
//   - a grant lost in the middle of an OWN window.
//   Functional behaviour is the same with or without the macro.
//
// Handshake: req_outputs[i] is a registered request that stays high until the
// job completes or reset. The grant is acted on only in the cycle it is
// sampled high at the rising edge. A low grant sampled in OWN aborts the job.

module rr_request_manager #(
    parameter int NUM_CLIENTS = 3,
    parameter int JOB_CNT_W   = 4,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_CLIENTS-1:0]           job_push,
    input  logic [NUM_CLIENTS-1:0]           grant_inputs,
    output logic [NUM_CLIENTS-1:0]           req_outputs,
    output logic [NUM_CLIENTS-1:0]           busy_outputs,
    output logic [NUM_CLIENTS-1:0]           job_done,
    output logic [NUM_CLIENTS-1:0]           overflow,
    output logic [NUM_CLIENTS*JOB_CNT_W-1:0] pending_flat
`ifdef RR_PROTOCOL_CHECK_EN
    ,
    output logic                             protocol_err
`endif
);

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_OWN     = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    localparam logic [JOB_CNT_W-1:0] PEND_MAX  = '1;
    localparam logic [HOLD_W-1:0]    HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

`ifdef RR_PROTOCOL_CHECK_EN
    logic [NUM_CLIENTS-1:0] w_can_take;
    logic [NUM_CLIENTS-1:0] w_lost;
`endif

    for (genvar gi = 0; gi < NUM_CLIENTS; gi++) begin : g_client
        logic [1:0]           r_state;
        logic [HOLD_W-1:0]    r_hold;
        logic [JOB_CNT_W-1:0] r_pend;
        logic                 r_req;
        logic                 r_busy;
        logic                 r_done;
        logic                 r_ovf;

        logic [1:0]           w_state_nxt;
        logic [HOLD_W-1:0]    w_hold_nxt;
        logic [JOB_CNT_W-1:0] w_pend_nxt;
        logic                 w_complete;
        logic                 w_ovf_set;

        // Next-state, hold counter and pending-count update for this client
        always_comb begin
            w_complete  = (r_state == ST_OWN) && grant_inputs[gi] && (r_hold == '0);
            w_ovf_set   = 1'b0;
            w_pend_nxt  = r_pend;
            w_state_nxt = r_state;
            w_hold_nxt  = r_hold;

            // Push and completion in the same cycle cancel out
            if (job_push[gi] && !w_complete) begin
                if (r_pend == PEND_MAX) begin
                    w_ovf_set = 1'b1;
                end else begin
                    w_pend_nxt = r_pend + 1'b1;
                end
            end else if (!job_push[gi] && w_complete) begin
                w_pend_nxt = r_pend - 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_pend_nxt != '0) begin
                        w_state_nxt = ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (grant_inputs[gi]) begin
                        w_state_nxt = ST_OWN;
                        w_hold_nxt  = HOLD_LOAD;
                    end
                end
                ST_OWN: begin
                    if (!grant_inputs[gi]) begin
                        // Grant lost: abort; the job restarts in full on the next grant
                        w_state_nxt = ST_REQ;
                    end else if (r_hold == '0) begin
                        w_state_nxt = ST_RELEASE;
                    end else begin
                        w_hold_nxt = r_hold - 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = (w_pend_nxt != '0) ? ST_REQ : ST_IDLE;
                end
            endcase
        end

        // State and registered outputs; outputs follow the next state so they align with it
        always_ff @(posedge clk) begin
            if (!rst) begin
                r_state <= ST_IDLE;
                r_hold  <= '0;
                r_pend  <= '0;
                r_req   <= 1'b0;
                r_busy  <= 1'b0;
                r_done  <= 1'b0;
                r_ovf   <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_hold  <= w_hold_nxt;
                r_pend  <= w_pend_nxt;
                r_req   <= (w_state_nxt == ST_REQ) || (w_state_nxt == ST_OWN);
                r_busy  <= (w_state_nxt == ST_OWN);
                r_done  <= w_complete;
                r_ovf   <= r_ovf | w_ovf_set;
            end
        end

        assign req_outputs[gi]                          = r_req;
        assign busy_outputs[gi]                         = r_busy;
        assign job_done[gi]                             = r_done;
        assign overflow[gi]                             = r_ovf;
        assign pending_flat[gi*JOB_CNT_W +: JOB_CNT_W] = r_pend;

`ifdef RR_PROTOCOL_CHECK_EN
        assign w_can_take[gi] = (r_state == ST_REQ) || (r_state == ST_OWN);
        assign w_lost[gi]     = (r_state == ST_OWN) && !grant_inputs[gi];
`endif
    end

`ifdef RR_PROTOCOL_CHECK_EN
    logic r_protocol_err;

    // Sticky flag for arbiter protocol violations seen at this edge
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_protocol_err <= 1'b0;
        end else if (((grant_inputs & ~w_can_take) != '0) ||
                     ($countones(grant_inputs) > 1) ||
                     (w_lost != '0)) begin
            r_protocol_err <= 1'b1;
        end
    end

    assign protocol_err = r_protocol_err;
`endif

endmodule

// File: tb/tb_rr_request_manager.sv
// Self-checking bench for rr_request_manager (3 clients, 4-bit counters, hold 4).
// The grant is a registered one-hot echo of req with a sticky round-robin owner.
// A transaction-level reference model predicts every output after each edge.
module tb_rr_request_manager;

  localparam int N    = 3;
  localparam int W    = 4;
  localparam int H    = 4;
  localparam int MAXP = 15;

  localparam int P_IDLE = 0;
  localparam int P_WAIT = 1;
  localparam int P_OWN  = 2;
  localparam int P_GAP  = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   job_push;
  logic [N-1:0]   grant_inputs;
  logic [N-1:0]   req_outputs;
  logic [N-1:0]   busy_outputs;
  logic [N-1:0]   job_done;
  logic [N-1:0]   overflow;
  logic [N*W-1:0] pending_flat;
`ifdef RR_PROTOCOL_CHECK_EN
  logic           protocol_err;
`endif

  rr_request_manager #(.NUM_CLIENTS(N), .JOB_CNT_W(W), .HOLD_CYCLES(H)) dut (
    .clk          (clk),
    .rst          (rst),
    .job_push     (job_push),
    .grant_inputs (grant_inputs),
    .req_outputs  (req_outputs),
    .busy_outputs (busy_outputs),
    .job_done     (job_done),
    .overflow     (overflow),
    .pending_flat (pending_flat)
`ifdef RR_PROTOCOL_CHECK_EN
    ,
    .protocol_err (protocol_err)
`endif
  );

  // clock
  always #5 clk = ~clk;

  // scoreboard counters
  int checks   = 0;
  int failures = 0;

  // reference model state
  int         m_pend  [N];
  int         m_phase [N];
  int         m_held  [N];
  logic [N-1:0] m_done;
  logic [N-1:0] m_ovf;
  logic         m_perr;

  // grant generator state
  int           owner   = -1;
  logic [N-1:0] gnt_reg = '0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] model_req();
    logic [N-1:0] r = '0;
    for (int i = 0; i < N; i++) r[i] = (m_phase[i] == P_WAIT) || (m_phase[i] == P_OWN);
    return r;
  endfunction

  function automatic logic [N-1:0] model_busy();
    logic [N-1:0] b = '0;
    for (int i = 0; i < N; i++) b[i] = (m_phase[i] == P_OWN);
    return b;
  endfunction

  function automatic logic [N*W-1:0] model_pend();
    logic [N*W-1:0] p = '0;
    for (int i = 0; i < N; i++) p[i*W +: W] = m_pend[i][W-1:0];
    return p;
  endfunction

  // round-robin one-hot pick with a sticky owner
  function automatic logic [N-1:0] pick(input logic [N-1:0] rq);
    logic [N-1:0] g = '0;
    logic found = 1'b0;
    if (owner >= 0 && rq[owner]) begin
      g[owner] = 1'b1;
    end else begin
      for (int k = 1; k <= N; k++) begin
        int c = (owner + k + N) % N;
        if (!found && rq[c]) begin
          found = 1'b1;
          owner = c;
          g[c]  = 1'b1;
        end
      end
    end
    return g;
  endfunction

  // one clock of the reference model
  task automatic model_step(input logic rst_v, input logic [N-1:0] push_v, input logic [N-1:0] g);
    logic [N-1:0] take;
    if (!rst_v) begin
      for (int i = 0; i < N; i++) begin
        m_pend[i] = 0; m_phase[i] = P_IDLE; m_held[i] = 0;
      end
      m_done = '0; m_ovf = '0; m_perr = 1'b0;
      return;
    end
    take = model_req();
    if (((g & ~take) != '0) || ($countones(g) > 1) || ((model_busy() & ~g) != '0)) m_perr = 1'b1;
    for (int i = 0; i < N; i++) begin
      logic complete;
      complete  = (m_phase[i] == P_OWN) && g[i] && (m_held[i] == H);
      m_done[i] = complete;
      if (push_v[i] && !complete) begin
        if (m_pend[i] == MAXP) m_ovf[i] = 1'b1;
        else m_pend[i]++;
      end else if (!push_v[i] && complete) begin
        m_pend[i]--;
      end
      case (m_phase[i])
        P_IDLE: if (m_pend[i] > 0) m_phase[i] = P_WAIT;
        P_WAIT: if (g[i]) begin m_phase[i] = P_OWN; m_held[i] = 1; end
        P_OWN: begin
          if (!g[i]) m_phase[i] = P_WAIT;
          else if (complete) m_phase[i] = P_GAP;
          else m_held[i]++;
        end
        default: m_phase[i] = (m_pend[i] > 0) ? P_WAIT : P_IDLE;
      endcase
    end
  endtask

  task automatic compare_all();
    check("req",     32'(req_outputs),  32'(model_req()));
    check("busy",    32'(busy_outputs), 32'(model_busy()));
    check("done",    32'(job_done),     32'(m_done));
    check("ovf",     32'(overflow),     32'(m_ovf));
    check("pending", 32'(pending_flat), 32'(model_pend()));
`ifdef RR_PROTOCOL_CHECK_EN
    check("perr",    32'(protocol_err), 32'(m_perr));
`endif
  endtask

  // driver: gmode 0 = echo grant, 1 = no grant, 2 = random grant
  task automatic step(input logic rst_v, input logic [N-1:0] push_v, input int gmode);
    logic [N-1:0] g;
    @(negedge clk);
    g = gnt_reg;
    if (gmode == 1) g = '0;
    else if (gmode == 2) g = N'($urandom_range(0, (1 << N) - 1));
    rst          = rst_v;
    job_push     = push_v;
    grant_inputs = g;
    gnt_reg      = pick(model_req());
    @(posedge clk);
    model_step(rst_v, push_v, g);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b1, '0, 0);
  endtask

  // step with echo grant until client c is in its 2nd owned cycle; bounded
  task automatic wait_own2(input int c, input string tag);
    logic found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (m_phase[c] == P_OWN && m_held[c] == 2) found = 1'b1;
      else step(1'b1, '0, 0);
    end
    check(tag, 32'(found), 32'd1);
  endtask

  initial begin
    rst = 1'b0; job_push = '0; grant_inputs = '0;
    for (int i = 0; i < N; i++) begin m_pend[i] = 0; m_phase[i] = P_IDLE; m_held[i] = 0; end
    m_done = '0; m_ovf = '0; m_perr = 1'b0;

    // 1: reset held with pushes active
    step(1'b0, 3'b111, 0);
    step(1'b0, 3'b111, 0);
    check("rst_all", 32'({req_outputs, busy_outputs, job_done, overflow}), 32'd0);
    step(1'b1, 3'b000, 0);
    check("rst_pend", 32'(pending_flat), 32'd0);

    // 2: single job on client 0
    step(1'b1, 3'b001, 0);
    check("c0_req", 32'(req_outputs[0]), 32'd1);
    idle(12);
    check("c0_pend0", 32'(pending_flat[0 +: W]), 32'd0);

    // 3: two jobs on client 1
    step(1'b1, 3'b010, 0);
    step(1'b1, 3'b010, 0);
    idle(16);
    check("c1_pend0", 32'(pending_flat[W +: W]), 32'd0);

    // 4: saturate client 2 without grants
    for (int k = 0; k < 16; k++) step(1'b1, 3'b100, 1);
    check("c2_sat", 32'(pending_flat[2*W +: W]), 32'd15);
    check("c2_ovf", 32'(overflow[2]), 32'd1);
    idle(100);
    check("c2_ovf_sticky", 32'(overflow[2]), 32'd1);

    // 5: grant lost in the 2nd owned cycle of client 0, then full rerun
    step(1'b1, 3'b001, 0);
    wait_own2(0, "wait_c0_own");
    step(1'b1, 3'b000, 1);
    check("abort_busy", 32'(busy_outputs[0]), 32'd0);
    check("abort_req",  32'(req_outputs[0]),  32'd1);
    idle(14);

    // 6: reset in the 2nd owned cycle of client 1 with 3 pending jobs
    step(1'b1, 3'b010, 0);
    step(1'b1, 3'b010, 0);
    step(1'b1, 3'b010, 0);
    wait_own2(1, "wait_c1_own");
    step(1'b0, 3'b000, 0);
    check("mid_rst_out", 32'({req_outputs, busy_outputs, job_done, overflow}), 32'd0);
    check("mid_rst_pend", 32'(pending_flat), 32'd0);

    // randomized traffic with occasional resets and grant disturbances
    for (int k = 0; k < 1500; k++) begin
      logic         r_v;
      logic [N-1:0] p_v;
      int           gm;
      int           roll;
      r_v  = ($urandom_range(0, 199) != 0);
      p_v  = '0;
      for (int i = 0; i < N; i++) p_v[i] = ($urandom_range(0, 5) == 0);
      roll = $urandom_range(0, 19);
      gm   = (roll < 16) ? 0 : ((roll < 18) ? 1 : 2);
      step(r_v, p_v, gm);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
